demux_1_to_4_buf: RTL and testbench

- Buffered 1-to-4 demultiplexer: the steering counterpart of the 4-to-1 select path.
- Accepts one word per cycle on a valid/ready input stream, tagged with a 2-bit destination select.
- Routes each word to one of four output channels (w, x, y, z).
- Each channel has its own 2-entry FIFO, so a stalled destination does not block words bound for other destinations. Used for result/writeback fan-out in the CRP16 datapath.

---
 rtl/demux_1_to_4_buf.sv | 93 +++++++++
 tb/tb_demux_1_to_4_buf.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/demux_1_to_4_buf.sv
// Buffered 1-to-4 demultiplexer: one valid/ready input stream steered by in_select
// into four independent 2-entry FIFOs (w, x, y, z), each with its own valid/ready.
module demux_1_to_4_buf #(
    parameter int bits = 16
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic [bits-1:0] in_data,
    input  logic [1:0]      in_select,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [bits-1:0] w,
    output logic [bits-1:0] x,
    output logic [bits-1:0] y,
    output logic [bits-1:0] z,
    output logic [3:0]      out_valid,
    input  logic [3:0]      out_ready
);

    logic [bits-1:0] mem_q [4][2];
    logic [bits-1:0] mem_d [4][2];
    logic            rd_q  [4];
    logic            rd_d  [4];
    logic            wr_q  [4];
    logic            wr_d  [4];
    logic [1:0]      cnt_q [4];
    logic [1:0]      cnt_d [4];

    logic [3:0]      push;
    logic [3:0]      pop;
    logic [bits-1:0] dout [4];

    // in_ready looks only at the registered count, so out_ready never reaches it.
    assign in_ready = (cnt_q[in_select] != 2'd2);

    always_comb begin
        push = '0;
        pop  = '0;
        for (int i = 0; i < 4; i++) begin
            out_valid[i] = (cnt_q[i] != 2'd0);
            dout[i]      = out_valid[i] ? mem_q[i][rd_q[i]] : '0;
            push[i]      = in_valid && in_ready && (in_select == 2'(i));
            pop[i]       = out_valid[i] && out_ready[i];
        end
    end

    assign w = dout[0];
    assign x = dout[1];
    assign y = dout[2];
    assign z = dout[3];

    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < 4; i++) begin
            rd_d[i]  = rd_q[i];
            wr_d[i]  = wr_q[i];
            cnt_d[i] = cnt_q[i];
            if (push[i]) begin
                mem_d[i][wr_q[i]] = in_data;
                wr_d[i]           = ~wr_q[i];
            end
            if (pop[i]) begin
                rd_d[i] = ~rd_q[i];
            end
            // A simultaneous push and pop leaves the count unchanged.
            if (push[i] && !pop[i]) begin
                cnt_d[i] = cnt_q[i] + 2'd1;
            end else if (pop[i] && !push[i]) begin
                cnt_d[i] = cnt_q[i] - 2'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i][0] <= '0;
                mem_q[i][1] <= '0;
                rd_q[i]     <= 1'b0;
                wr_q[i]     <= 1'b0;
                cnt_q[i]    <= 2'd0;
            end
        end else begin
            mem_q <= mem_d;
            for (int i = 0; i < 4; i++) begin
                rd_q[i]  <= rd_d[i];
                wr_q[i]  <= wr_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_demux_1_to_4_buf.sv
// Bench for demux_1_to_4_buf: directed scenarios plus random traffic, all checked
// against per-channel queues that model the four 2-deep FIFOs.
module tb_demux_1_to_4_buf;

    logic        clock = 1'b0;
    logic        resetn;
    logic [15:0] in_data;
    logic [1:0]  in_select;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] w, x, y, z;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;

    demux_1_to_4_buf #(.bits(16)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_data   (in_data),
        .in_select (in_select),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .w         (w),
        .x         (x),
        .y         (y),
        .z         (z),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] q [4][$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] chan_out(input int i);
        case (i)
            0:       return w;
            1:       return x;
            2:       return y;
            default: return z;
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        logic [3:0]  ev;
        logic [15:0] ed;
        for (int i = 0; i < 4; i++) begin
            ev[i] = (q[i].size() != 0);
            ed    = ev[i] ? q[i][0] : 16'h0000;
            check($sformatf("%s data%0d", tag, i), {16'h0, chan_out(i)}, {16'h0, ed});
        end
        check({tag, " out_valid"}, {28'h0, out_valid}, {28'h0, ev});
        check({tag, " in_ready"}, {31'h0, in_ready}, {31'h0, q[in_select].size() < 2});
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic cycle(input string tag, input logic v, input logic [1:0] sel,
                         input logic [15:0] d, input logic [3:0] ordy, output logic acc);
        in_valid  = v;
        in_select = sel;
        in_data   = d;
        out_ready = ordy;
        #1;
        check_outputs(tag);
        acc = v && (q[sel].size() < 2);
        for (int i = 0; i < 4; i++)
            if (ordy[i] && q[i].size() != 0) void'(q[i].pop_front());
        if (acc) q[sel].push_back(d);
        @(negedge clock);
    endtask

    task automatic drain(input string tag);
        logic acc;
        for (int k = 0; k < 3; k++) cycle(tag, 1'b0, 2'd0, 16'h0, 4'b1111, acc);
    endtask

    initial begin
        logic        acc;
        logic        pend;
        logic [1:0]  psel;
        logic [15:0] pdat;

        resetn = 1'b0;
        in_valid = 1'b0; in_select = 2'd0; in_data = 16'h0; out_ready = 4'b0;
        #2;
        check_outputs("por");
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        // Mid-cycle asynchronous reset with channel y full
        cycle("fill_y", 1'b1, 2'd2, 16'hBEEF, 4'b0000, acc);
        cycle("fill_y", 1'b1, 2'd2, 16'hCAFE, 4'b0000, acc);
        in_valid = 1'b0; in_select = 2'd2;
        #2;
        resetn = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) q[i].delete();
        check("rst out_valid", {28'h0, out_valid}, 32'h0);
        check("rst y", {16'h0, y}, 32'h0);
        check("rst in_ready", {31'h0, in_ready}, 32'h1);
        @(negedge clock);
        resetn = 1'b1;
        cycle("post_rst", 1'b0, 2'd2, 16'h0, 4'b1111, acc);
        cycle("post_rst", 1'b0, 2'd2, 16'h0, 4'b1111, acc);

        // Single route
        cycle("single", 1'b1, 2'd2, 16'hA5A5, 4'b1111, acc);
        check("single acc", {31'h0, acc}, 32'h1);
        cycle("single+1", 1'b0, 2'd0, 16'h0, 4'b1111, acc);
        cycle("single+2", 1'b0, 2'd0, 16'h0, 4'b1111, acc);

        // Fill and backpressure on x
        cycle("bp1", 1'b1, 2'd1, 16'h0001, 4'b0000, acc);
        cycle("bp2", 1'b1, 2'd1, 16'h0002, 4'b0000, acc);
        in_valid = 1'b1; in_select = 2'd1; #1;
        check("bp full sel1", {31'h0, in_ready}, 32'h0);
        in_select = 2'd3; #1;
        check("bp sel3", {31'h0, in_ready}, 32'h1);
        cycle("bp3", 1'b1, 2'd1, 16'h0003, 4'b0010, acc);
        check("bp3 stalled", {31'h0, acc}, 32'h0);
        cycle("bp3 retry", 1'b1, 2'd1, 16'h0003, 4'b0010, acc);
        check("bp3 accepted", {31'h0, acc}, 32'h1);
        drain("bp drain");

        // Simultaneous push/pop at count 1
        cycle("pp load", 1'b1, 2'd0, 16'h1111, 4'b0000, acc);
        cycle("pp both", 1'b1, 2'd0, 16'h2222, 4'b0001, acc);
        cycle("pp hold", 1'b0, 2'd0, 16'h0, 4'b0000, acc);
        cycle("pp pop", 1'b0, 2'd0, 16'h0, 4'b0001, acc);
        cycle("pp empty", 1'b0, 2'd0, 16'h0, 4'b0000, acc);

        // Independent channels with y stalled and full
        cycle("ind fill", 1'b1, 2'd2, 16'h7000, 4'b1011, acc);
        cycle("ind fill", 1'b1, 2'd2, 16'h7001, 4'b1011, acc);
        for (int k = 0; k < 8; k++) begin
            cycle("ind rr", 1'b1, 2'(k % 4), 16'h8000 + 16'(k), 4'b1011, acc);
            check("ind acc", {31'h0, acc}, {31'h0, (k % 4) != 2});
        end
        drain("ind drain");

        // Random regression, producer holds a stalled word stable
        pend = 1'b0; psel = 2'd0; pdat = 16'h0;
        for (int k = 0; k < 10000; k++) begin
            logic v;
            if (!pend) begin
                v    = ($urandom_range(0, 3) != 0);
                psel = 2'($urandom_range(0, 3));
                pdat = 16'($urandom);
            end else begin
                v = 1'b1;
            end
            cycle("rand", v, psel, pdat, 4'($urandom), acc);
            pend = v && !acc;
        end
        drain("rand drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
